uart_tx: RTL
============

Name: uart_tx

Overview:
- Serial transmitter half of the UART; complements the receive path.
- Accepts a parallel byte with a one-cycle valid strobe and serializes it onto TX_OUT as a standard asynchronous frame: start bit, data bits LSB first, optional parity bit, stop bit.
- Clocked by the TX bit clock (already divided down by the clock-divider block), so one CLK period equals one bit time.
- Busy is fed back to the upstream FIFO/controller for flow control.

Parameters:
- DATA_WIDTH, 8, number of payload bits per frame.

Ports:
- CLK  input  1  TX bit clock; one bit per rising edge.
- RST  input  1  reset, asynchronous, active-low.
- P_DATA  input  DATA_WIDTH  parallel payload; sampled only on an accept edge.
- Data_Valid  input  1  request strobe; P_DATA is valid while high.
- PAR_EN  input  1  1 = insert a parity bit; sampled on an accept edge.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled on an accept edge.
- TX_OUT  output  1  serial line, registered, idles high.
- Busy  output  1  registered; 1 while a frame is on the line.

Behaviour:
- Reset (RST low, asynchronous, any time including mid-frame):
  - state = IDLE, TX_OUT = 1, Busy = 0.
  - shift register, bit counter and latched config = 0.
  - No partial frame resumes after release.
- States and the value driven on TX_OUT during each:
  - IDLE: 1.
  - START: 0.
  - DATA: latched bit[n], n = 0..DATA_WIDTH-1, LSB first.
  - PARITY: latched parity bit.
  - STOP: 1.
- Accept edge: a rising CLK where Data_Valid = 1 and state is IDLE or STOP.
  - Latches P_DATA, PAR_EN and PAR_TYP.
  - Computes parity from the latched data:
    - even: XOR of the data bits;
    - odd: inverted XOR of the data bits.
  - Next state = START.
- Data_Valid while in START, DATA or PARITY: ignored; no queuing.
- Changes to P_DATA, PAR_EN or PAR_TYP after the accept edge have no effect on the current frame.
- Transitions (every state lasts exactly one CLK):
  - IDLE -> START on accept; otherwise stays in IDLE.
  - START -> DATA.
  - DATA -> DATA while bit counter < DATA_WIDTH-1, then:
    - PARITY if latched PAR_EN = 1;
    - STOP otherwise.
  - PARITY -> STOP.
  - STOP -> START on accept (back-to-back, no idle gap); otherwise -> IDLE.
- Bit counter width: clog2(DATA_WIDTH). Cleared on entry to DATA; increments each DATA cycle; no wrap is observable.
- Latency: the accept edge E0 makes TX_OUT = 0 (start bit) and Busy = 1 immediately after E0.
- Frame length: DATA_WIDTH+2 cycles, or DATA_WIDTH+3 cycles with parity (10 or 11 for the default width).
- Busy:
  - 1 in START, DATA, PARITY and STOP; 0 only in IDLE.
  - Stays 1 continuously across back-to-back frames.
  - Deasserts on the edge that leaves STOP without an accept.
- Glitch-free output: TX_OUT and Busy come from flops; there is no combinational path from any input to them.
- Upstream contract: the producer may hold Data_Valid high; one frame is taken per accept edge.

Test Plan:
1. Even parity, single frame:
   - Stimulus: after reset, P_DATA = 0xA5, PAR_EN = 1, PAR_TYP = 0, Data_Valid pulsed for 1 cycle.
   - Required: TX_OUT per cycle = 0,1,0,1,0,0,1,0,1,0,1, then 1 idle.
   - Required: Busy high for exactly 11 cycles.
2. No parity, minimum frame:
   - Stimulus: P_DATA = 0x00, PAR_EN = 0.
   - Required: TX_OUT = 0, eight 0s, then 1; Busy high for exactly 10 cycles; returns to IDLE.
3. Odd parity, back-to-back frames:
   - Stimulus: P_DATA = 0xFF with PAR_EN = 1, PAR_TYP = 1; Data_Valid held high through the stop bit while P_DATA is switched to 0x01.
   - Required, first frame: 0, eight 1s, parity 1, stop 1.
   - Required, second frame starts with 0 on the very next cycle: 0,1,0,0,0,0,0,0,0, parity 0, stop 1.
   - Required: Busy never drops between the two frames.
4. Mid-frame input changes ignored:
   - Stimulus: start 0x3C (no parity); in cycles 2–6 toggle Data_Valid and change P_DATA to 0xC3 and PAR_EN to 1.
   - Required: the line carries exactly the 0x3C frame (0,0,0,1,1,1,1,0,0,1), 10 cycles, and no extra frame follows.
5. Reset mid-frame:
   - Stimulus: assert RST low during data bit 3 of a 0x5A frame.
   - Required: TX_OUT = 1 and Busy = 0 immediately, without waiting for CLK.
   - Required: after RST release with Data_Valid = 0, the line stays at 1.
   - Required: a new 0x81 request then produces a clean full frame.
6. Idle hold:
   - Stimulus: Data_Valid = 0 for 50 cycles after reset.
   - Required: TX_OUT = 1 and Busy = 0 on every cycle.

Source files
------------

// File: rtl/uart_tx.sv
// UART serial transmitter: frames a parallel byte as start, LSB-first data,
// optional parity and stop bit, one bit per CLK (CLK is the bit clock).
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] shift_q, shift_next;
  logic [CNT_W-1:0]      cnt_q, cnt_next;
  logic                  par_en_q, par_en_next;
  logic                  par_bit_q, par_bit_next;
  logic                  tx_next, busy_next;

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data,
                                      input logic                  odd);
    return (^data) ^ odd;
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      TX_OUT    <= 1'b1;
      Busy      <= 1'b0;
    end else begin
      state     <= state_next;
      shift_q   <= shift_next;
      cnt_q     <= cnt_next;
      par_en_q  <= par_en_next;
      par_bit_q <= par_bit_next;
      TX_OUT    <= tx_next;
      Busy      <= busy_next;
    end
  end

  // Line value and Busy are decoded from the next state so both leave flops
  // aligned with the state they describe.
  always_comb begin
    state_next   = state;
    shift_next   = shift_q;
    cnt_next     = cnt_q;
    par_en_next  = par_en_q;
    par_bit_next = par_bit_q;
    tx_next      = 1'b1;
    busy_next    = 1'b1;

    case (state)
      IDLE, STOP: begin
        if (Data_Valid) begin
          state_next   = START;
          shift_next   = P_DATA;
          par_en_next  = PAR_EN;
          par_bit_next = parity_bit(P_DATA, PAR_TYP);
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        state_next = DATA;
        cnt_next   = '0;
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          state_next = par_en_q ? PARITY : STOP;
        end else begin
          cnt_next = cnt_q + 1'b1;
        end
      end
      PARITY: state_next = STOP;
      default: state_next = IDLE;
    endcase

    case (state_next)
      IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
      end
      START: tx_next = 1'b0;
      DATA: begin
        tx_next    = shift_q[0];
        shift_next = shift_q >> 1;
      end
      PARITY: tx_next = par_bit_q;
      default: tx_next = 1'b1;
    endcase
  end

endmodule
